// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing: load-use and ecall/x17 stalls, halt drain, sticky halt.
// Optional counters are enabled by defining PIPE_HAZARD_STATS_EN.
module pipeline_hazard_controller #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] HALT_CODE    = 32'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_is_ecall,
  input  logic [31:0] id_x17,
  input  logic        ex_mem_read,
  input  logic        ex_reg_write,
  input  logic [4:0]  ex_rd,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_rd,
  input  logic        wb_reg_write,
  input  logic [4:0]  wb_rd,
`ifdef PIPE_HAZARD_STATS_EN
  output logic [31:0] stat_stall_cycles,
  output logic [31:0] stat_halt_cycle,
`endif
  output logic        pc_write_enable,
  output logic        if_id_write_enable,
  output logic        id_ex_bubble,
  output logic        halt_pending,
  output logic        is_halted
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [4:0] X17 = 5'd17;

  state_t     state;
  logic [2:0] drain_cnt;

  logic rs1_hit;
  logic rs2_hit;
  logic lu_haz;
  logic x17_haz;
  logic stall;
  logic halt_go;

  assign rs1_hit = id_use_rs1 && (ex_rd == id_rs1);
  assign rs2_hit = id_use_rs2 && (ex_rd == id_rs2);

  assign lu_haz = ex_mem_read && (ex_rd != 5'd0)
               && (rs1_hit || rs2_hit);

  // rd==17 is never x0, so no explicit zero check is needed here
  assign x17_haz = id_is_ecall
                && ((ex_reg_write && ex_rd == X17)
                 || (mem_reg_write && mem_rd == X17)
                 || (wb_reg_write && wb_rd == X17));

  assign stall   = lu_haz || x17_haz;
  assign halt_go = id_is_ecall && !x17_haz
                && (id_x17 == HALT_CODE);

  always_comb begin
    pc_write_enable    = 1'b1;
    if_id_write_enable = 1'b1;
    id_ex_bubble       = 1'b0;
    if (reset) begin
      unique case (1'b1)
        (state != RUN),
        stall: begin
          pc_write_enable    = 1'b0;
          if_id_write_enable = 1'b0;
          id_ex_bubble       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      drain_cnt    <= 3'd0;
      halt_pending <= 1'b0;
      is_halted    <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (halt_go && !stall) begin
            state        <= DRAIN;
            drain_cnt    <= 3'(DRAIN_CYCLES);
            halt_pending <= 1'b1;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - 3'd1;
          if (drain_cnt == 3'd1) begin
            state        <= HALTED;
            halt_pending <= 1'b0;
            is_halted    <= 1'b1;
          end
        end
        HALTED: ;
        default: begin
          state        <= RUN;
          halt_pending <= 1'b0;
          is_halted    <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] cycle_cnt;
  logic        halt_enter;

  assign halt_enter = (state == DRAIN)
                   && (drain_cnt == 3'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt         <= 32'd0;
      stat_stall_cycles <= 32'd0;
      stat_halt_cycle   <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state == RUN && stall
          && stat_stall_cycles != 32'hFFFF_FFFF)
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      if (halt_enter)
        stat_halt_cycle <= cycle_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: directed cases, then random
// stimulus checked against a cycle-indexed behavioural model.
module tb_pipeline_hazard_controller;

  localparam int D = 3;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        id_is_ecall;
  logic [31:0] id_x17;
  logic        ex_mem_read;
  logic        ex_reg_write, mem_reg_write, wb_reg_write;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic        pc_write_enable, if_id_write_enable;
  logic        id_ex_bubble, halt_pending, is_halted;
`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] stat_stall_cycles, stat_halt_cycle;
`endif

  pipeline_hazard_controller #(
    .DRAIN_CYCLES(D),
    .HALT_CODE(32'd10)
  ) dut (
    .clk(clk),
    .reset(reset),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .id_is_ecall(id_is_ecall),
    .id_x17(id_x17),
    .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write),
    .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write),
    .mem_rd(mem_rd),
    .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd),
`ifdef PIPE_HAZARD_STATS_EN
    .stat_stall_cycles(stat_stall_cycles),
    .stat_halt_cycle(stat_halt_cycle),
`endif
    .pc_write_enable(pc_write_enable),
    .if_id_write_enable(if_id_write_enable),
    .id_ex_bubble(id_ex_bubble),
    .halt_pending(halt_pending),
    .is_halted(is_halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // model: cycle index of the accepted halting ecall, -1 if none
  int halt_t = -1;
  int mcyc   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic bit m_stall();
    bit lu, xh;
    lu = ex_mem_read && ex_rd != 0
      && ((id_use_rs1 && ex_rd == id_rs1)
       || (id_use_rs2 && ex_rd == id_rs2));
    xh = m_x17h();
    return lu || xh;
  endfunction

  function automatic bit m_x17h();
    return id_is_ecall
      && ((ex_reg_write && ex_rd == 17)
       || (mem_reg_write && mem_rd == 17)
       || (wb_reg_write && wb_rd == 17));
  endfunction

  function automatic bit m_halt_go();
    return id_is_ecall && !m_x17h() && id_x17 == 32'd10;
  endfunction

  function automatic bit m_drain();
    return halt_t >= 0 && mcyc > halt_t && mcyc <= halt_t + D;
  endfunction

  function automatic bit m_halted();
    return halt_t >= 0 && mcyc > halt_t + D;
  endfunction

  task automatic check_model();
    bit frz, dr, hl;
    dr  = reset && m_drain();
    hl  = reset && m_halted();
    frz = reset && (dr || hl || m_stall());
    chk("pc_we",  32'(pc_write_enable),    32'(!frz));
    chk("ifid_we", 32'(if_id_write_enable), 32'(!frz));
    chk("bubble", 32'(id_ex_bubble),       32'(frz));
    chk("halt_pending", 32'(halt_pending), 32'(dr));
    chk("is_halted", 32'(is_halted),       32'(hl));
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) halt_t = -1;
    else begin
      if (halt_t < 0 && m_halt_go() && !m_stall())
        halt_t = mcyc;
      mcyc++;
    end
    #1;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0;
    id_use_rs1 = 0; id_use_rs2 = 0;
    id_is_ecall = 0; id_x17 = 0;
    ex_mem_read = 0;
    ex_reg_write = 0; ex_rd = 0;
    mem_reg_write = 0; mem_rd = 0;
    wb_reg_write = 0; wb_rd = 0;
  endtask

  function automatic logic [4:0] rreg();
    case ($urandom_range(0, 3))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd17;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  task automatic rand_in();
    id_rs1 = rreg(); id_rs2 = rreg();
    id_use_rs1 = 1'($urandom);
    id_use_rs2 = 1'($urandom);
    id_is_ecall = ($urandom_range(0, 3) == 0);
    case ($urandom_range(0, 3))
      0: id_x17 = 32'd10;
      1: id_x17 = 32'd7;
      2: id_x17 = 32'd17;
      default: id_x17 = $urandom;
    endcase
    ex_mem_read = 1'($urandom);
    ex_reg_write = 1'($urandom); ex_rd = rreg();
    mem_reg_write = 1'($urandom); mem_rd = rreg();
    wb_reg_write = 1'($urandom); wb_rd = rreg();
  endtask

  task automatic lit3(input string nm, input logic [2:0] want);
    chk(nm, 32'({pc_write_enable, if_id_write_enable,
                 id_ex_bubble}), 32'(want));
  endtask

  initial begin
    idle();
    reset = 1'b0;
    // reset values hold even with a load-use pattern on the inputs
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    lit3("rst_ctl", 3'b110);
    chk("rst_hp", 32'(halt_pending), 0);
    chk("rst_ih", 32'(is_halted), 0);
    check_model();
    tick(); tick();
    #2 reset = 1'b1;
    idle();
    tick();

    // load-use: one stall cycle then free
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1 lit3("lu_stall", 3'b001); check_model();
    tick();
    ex_mem_read = 0; mem_reg_write = 1; mem_rd = 5;
    #1 lit3("lu_release", 3'b110); check_model();
    tick();

    // load into x0 never stalls
    idle();
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1 lit3("lu_x0", 3'b110); check_model();
    tick();

    // non-halting ecall
    idle();
    id_is_ecall = 1; id_x17 = 7;
    #1 lit3("ecall7", 3'b110); check_model();
    tick();
    #1 chk("ecall7_hp", 32'(halt_pending), 0);
    chk("ecall7_ih", 32'(is_halted), 0);
    check_model();

    // ecall waits for x17 writer in MEM then WB, then halts
    idle();
    id_is_ecall = 1; id_x17 = 10;
    mem_reg_write = 1; mem_rd = 17;
    #1 lit3("x17_mem", 3'b001); check_model();
    tick();
    mem_reg_write = 0; wb_reg_write = 1; wb_rd = 17;
    #1 lit3("x17_wb", 3'b001); check_model();
    tick();
    wb_reg_write = 0;
    #1 lit3("halt_go", 3'b110);
    chk("halt_go_hp", 32'(halt_pending), 0);
    check_model();
    tick();
    for (int i = 0; i < D; i++) begin
      #1 chk("drain_hp", 32'(halt_pending), 1);
      lit3("drain_ctl", 3'b001);
      check_model();
      tick();
    end
    for (int i = 0; i < 21; i++) begin
      rand_in();
      #1 chk("halted_ih", 32'(is_halted), 1);
      check_model();
      tick();
    end

    // async reset while in DRAIN
    reset = 1'b0;
    #1 halt_t = -1;
    tick();
    #2 reset = 1'b1;
    idle();
    id_is_ecall = 1; id_x17 = 10;
    #1 check_model();
    tick();
    idle();
    #1 chk("pre_rst_hp", 32'(halt_pending), 1);
    check_model();
    #2 reset = 1'b0;
    halt_t = -1;
    #1 chk("async_hp", 32'(halt_pending), 0);
    lit3("async_ctl", 3'b110);
`ifdef PIPE_HAZARD_STATS_EN
    chk("async_stat", stat_stall_cycles, 0);
`endif
    check_model();
    tick();
    #2 reset = 1'b1;
    tick();

    // randomized phase
    for (int n = 0; n < 4000; n++) begin
      rand_in();
      #1 check_model();
      if (reset && ($urandom_range(0, 99) == 0
          || (halt_t >= 0 && mcyc > halt_t + D + 8))) begin
        #1 reset = 1'b0;
        halt_t = -1;
        #1 check_model();
      end else if (!reset && $urandom_range(0, 1) == 0) begin
        #1 reset = 1'b1;
        #1 check_model();
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB). It decides every cycle whether the PC and the IF/ID register advance and whether a bubble is injected into ID/EX. It detects load-use hazards and ecall operand hazards on x17. On a halting ecall (x17 == 10) it drains the instructions ahead of the ecall and then raises a sticky `is_halted`. It sits beside the forwarding logic in `cpu` and drives `pc_write_enable`, `IF_ID_reg_write_enable` and the ID/EX control-zeroing input.

## Interface
Parameters:
- `DRAIN_CYCLES`, 3: cycles spent in DRAIN before HALTED (EX, MEM and WB must empty); legal range 1–7.
- `HALT_CODE`, 10: x17 value that makes an ecall halt.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `id_rs1`, `id_rs2`  in  5 each  source register IDs of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction actually reads rs1 / rs2.
- `id_is_ecall`  in  1  ID instruction is ecall.
- `id_x17`  in  32  register-file read of x17 in ID.
- `ex_mem_read`  in  1  instruction in EX is a load.
- `ex_reg_write`, `ex_rd`  in  1, 5  EX writeback enable and destination.
- `mem_reg_write`, `mem_rd`  in  1, 5  MEM writeback enable and destination.
- `wb_reg_write`, `wb_rd`  in  1, 5  WB writeback enable and destination.
- `pc_write_enable`  out  1  PC may update.
- `if_id_write_enable`  out  1  IF/ID may load.
- `id_ex_bubble`  out  1  ID/EX loads all-zero control signals (NOP).
- `halt_pending`  out  1  state is DRAIN.
- `is_halted`  out  1  pipeline is drained after a halting ecall; sticky.

## Operation
States: RUN, DRAIN, HALTED (registered); `drain_cnt` is a 3-bit counter.

Hazard terms (combinational, evaluated in RUN only):
- `lu_haz = ex_mem_read & ex_rd!=0 & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2))`
- `x17_haz = id_is_ecall & ((ex_reg_write & ex_rd==17) | (mem_reg_write & mem_rd==17) | (wb_reg_write & wb_rd==17))`
- `stall = lu_haz | x17_haz`
- `halt_go = id_is_ecall & ~x17_haz & id_x17==HALT_CODE`

Outputs by state:
- RUN:
  - If `stall`: `pc_write_enable=0`, `if_id_write_enable=0`, `id_ex_bubble=1`.
  - Otherwise: 1, 1, 0.
  - `halt_go` lets the ecall advance normally into EX and moves to DRAIN at the edge.
- DRAIN:
  - `pc_write_enable=0`, `if_id_write_enable=0`, `id_ex_bubble=1`; the stale ecall held in IF/ID is never re-issued.
  - `drain_cnt` loads `DRAIN_CYCLES` on entry and decrements each edge; the edge at `drain_cnt==1` moves to HALTED.
- HALTED:
  - Outputs stay as in DRAIN, with `is_halted=1`.
  - No exit except reset; all inputs are ignored.

Priority: `stall` overrides `halt_go`. An ecall with x17 in flight waits until the hazard clears, then re-evaluates `id_x17`.

Registers x0 never produce a hazard, including x17 checks on `rd==0`. A non-halting ecall (x17 ≠ HALT_CODE) behaves as an ordinary instruction.

## Timing
- Reset (async, `reset`=0): state=RUN, `drain_cnt`=0. Outputs while in reset: `pc_write_enable=1`, `if_id_write_enable=1`, `id_ex_bubble=0`, `halt_pending=0`, `is_halted=0`. Deassertion takes effect at the next rising edge.
- Load-use: a stall lasts exactly 1 cycle, because the load has moved to MEM at the next edge. Back-to-back dependent loads each cost 1 cycle.
- x17 hazard: stall for 1–3 cycles, until the writer leaves WB.
- Halt: ecall in ID at cycle T with `halt_go` means DRAIN during T+1..T+DRAIN_CYCLES, and `is_halted=1` from T+DRAIN_CYCLES+1 onward.
- Reset asserted in DRAIN or HALTED returns to RUN immediately (asynchronous).
- All outputs except `is_halted` and `halt_pending` are combinational from inputs and state. Those two are registered-state decodes.

## Configuration
- `PIPE_HAZARD_STATS_EN` defined:
  - Adds output `stat_stall_cycles` [31:0], which counts cycles in RUN with `stall=1` and saturates at 0xFFFFFFFF.
  - Adds output `stat_halt_cycle` [31:0], which latches a free-running cycle count at entry to HALTED.
  - Both reset to 0.
- Undefined: neither port nor its counters exist; the rest of the behaviour is identical.

## Test plan
- `lw x5` in EX with `ex_mem_read=1`, `ex_rd=5`; `add` in ID with `id_rs1=5`, `id_use_rs1=1` -> exactly one cycle of `pc_write_enable=0`, `if_id_write_enable=0`, `id_ex_bubble=1`, then 1,1,0.
- Load with `ex_rd=0` and `id_rs1=0` -> no stall.
- Ecall in ID, `id_x17=10`, no x17 writers -> `halt_pending=1` for cycles T+1..T+3, `is_halted=1` at T+4 and held for 20 further cycles.
- Ecall in ID with `mem_reg_write=1`, `mem_rd=17` -> stall; next cycle the writer is in WB -> stall; then `id_x17=10` -> DRAIN.
- Ecall with `id_x17=7` -> no DRAIN, pipeline continues, `is_halted` stays 0.
- Pull `reset` low during DRAIN, between clock edges -> state RUN and all outputs at reset values immediately. With `PIPE_HAZARD_STATS_EN`, the stall counter also clears to 0.
